// File: rtl/fpu_resp_credit_buffer.sv
// Credit-managed response buffer between a requester and an FPU wrapper.
// Requests are only forwarded while credits remain. A credit covers an
// operation from issue until its result is popped by the consumer. Results
// are stored in a first-word-fall-through FIFO in the order the FPU returns
// them. Protocol errors, meaning unexpected or unstorable results, raise a
// sticky overflow flag.
module fpu_resp_credit_buffer #(
    parameter int ID_WIDTH        = 9,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int DEPTH           = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         req_i,
    output logic                         gnt_o,

    output logic                         fpu_req_o,
    input  logic                         fpu_gnt_i,

    input  logic                         fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]        fpu_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0]   fpu_rflags_i,
    input  logic [ID_WIDTH-1:0]          fpu_rID_i,

    output logic                         rvalid_o,
    input  logic                         rready_i,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0]   rflags_o,
    output logic [ID_WIDTH-1:0]          rID_o,

    output logic [$clog2(DEPTH+1)-1:0]   credits_o,
    output logic                         overflow_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W   = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);

    // Occupancy state
    logic [CW-1:0] inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;

    // Payload storage; not reset because it is only observed while rvalid_o = 1
    logic [DATA_WIDTH-1:0]      data_mem  [DEPTH];
    logic [FLAGS_OUT_WIDTH-1:0] flags_mem [DEPTH];
    logic [ID_WIDTH-1:0]        id_mem    [DEPTH];

    // Per-cycle events
    logic          has_credit;
    logic          issue;
    logic          ret_ok;
    logic          ret_orphan;
    logic          pop;
    logic          full;
    logic          store;
    logic          drop;
    logic [CW:0]   used_w;
    logic [CW:0]   free_w;

    // Free credits, clamped at zero so that a spurious stored result cannot
    // make the subtraction wrap around
    always_comb begin
        used_w    = {1'b0, inflight} + {1'b0, count};
        free_w    = DEPTH_W - used_w;
        credits_o = '0;
        if (used_w < DEPTH_W) begin
            credits_o = free_w[CW-1:0];
        end
    end

    // Handshake gating and event decode
    always_comb begin
        has_credit = (credits_o != '0);
        fpu_req_o  = req_i & has_credit;
        gnt_o      = fpu_gnt_i & has_credit;
        issue      = fpu_req_o & fpu_gnt_i;

        rvalid_o   = (count != '0);
        pop        = rvalid_o & rready_i;
        full       = (count == DEPTH_C);

        ret_ok     = fpu_rvalid_i & (inflight != '0);
        ret_orphan = fpu_rvalid_i & (inflight == '0);
        // Storing into a full buffer is allowed when the head leaves in the same cycle
        store      = fpu_rvalid_i & (~full | pop);
        drop       = fpu_rvalid_i & full & ~pop;
    end

    // Head entry is presented combinationally (first-word fall-through)
    always_comb begin
        rdata_o  = data_mem[head_ptr];
        rflags_o = flags_mem[head_ptr];
        rID_o    = id_mem[head_ptr];
    end

    // In-flight operation counter: +1 on issue, -1 on a matched return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            case ({issue, ret_ok})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Stored entry counter: +1 on store, -1 on pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Circular head/tail pointers wrapping from DEPTH-1 back to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (pop) begin
                head_ptr <= (head_ptr == LAST_SLOT) ? '0 : head_ptr + 1'b1;
            end
            if (store) begin
                tail_ptr <= (tail_ptr == LAST_SLOT) ? '0 : tail_ptr + 1'b1;
            end
        end
    end

    // Payload write into the tail slot
    always_ff @(posedge clk) begin
        if (store) begin
            data_mem[tail_ptr]  <= fpu_rdata_i;
            flags_mem[tail_ptr] <= fpu_rflags_i;
            id_mem[tail_ptr]    <= fpu_rID_i;
        end
    end

    // Sticky protocol-error flag: result without an outstanding op, or no room to store it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_o <= 1'b0;
        end else if (ret_orphan | drop) begin
            overflow_o <= 1'b1;
        end
    end

endmodule

// File: doc/fpu_resp_credit_buffer.md
FPU_RESP_CREDIT_BUFFER -- requirements
Module: fpu_resp_credit_buffer

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 9, width of the transaction tag.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of the result word.
REQ-003 SHALL have parameter FLAGS_OUT_WIDTH, default 5, width of the FP status flags.
REQ-004 SHALL have parameter DEPTH, default 4, number of response entries (legal range 1..16).
REQ-005 SHALL have ports: clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have: req_i  input  1  requester issues an FPU operation.
REQ-008 SHALL have: gnt_o  output  1  requester operation accepted.
REQ-009 SHALL have: fpu_req_o  output  1  gated request to the FPU wrapper.
REQ-010 SHALL have: fpu_gnt_i  input  1  FPU wrapper ready/grant.
REQ-011 SHALL have: fpu_rvalid_i  input  1  FPU result valid (cannot be back-pressured).
REQ-012 SHALL have: fpu_rdata_i / fpu_rflags_i / fpu_rID_i  input  DATA_WIDTH / FLAGS_OUT_WIDTH / ID_WIDTH  FPU result payload.
REQ-013 SHALL have: rvalid_o  output  1  buffered result available.
REQ-014 SHALL have: rready_i  input  1  consumer accepts result.
REQ-015 SHALL have: rdata_o / rflags_o / rID_o  output  DATA_WIDTH / FLAGS_OUT_WIDTH / ID_WIDTH  head-of-buffer payload.
REQ-016 SHALL have: credits_o  output  $clog2(DEPTH+1)  free credits.
REQ-017 SHALL have: overflow_o  output  1  sticky protocol-error flag.

Function
REQ-018 SHALL keep counters inflight (issued, result not yet returned) and count (entries stored), each $clog2(DEPTH+1) bits; credits_o = DEPTH - inflight - count, combinational.
REQ-019 SHALL drive fpu_req_o = req_i & (credits_o != 0) and gnt_o = fpu_gnt_i & (credits_o != 0), combinationally; no request reaches the FPU with zero credits.
REQ-020 SHALL count an issue when fpu_req_o & fpu_gnt_i in a cycle; inflight +1 next edge.
REQ-021 SHALL on fpu_rvalid_i write payload into tail entry and increment count, and decrement inflight, in the same edge.
REQ-022 SHALL pop head when rvalid_o & rready_i; count -1 next edge.
REQ-023 SHALL apply issue, return and pop in the same cycle as net updates: inflight += issue - return; count += return - pop.
REQ-024 SHALL be a FIFO (circular, head/tail pointers wrapping DEPTH-1 -> 0) with first-word-fall-through: rvalid_o = (count != 0), rdata_o/rflags_o/rID_o = head entry, combinational.
REQ-025 SHALL NOT forward fpu_rvalid_i to rvalid_o in the same cycle (minimum result latency through the block: 1 cycle).
REQ-026 SHALL keep the head payload stable while rvalid_o & ~rready_i.
REQ-027 SHALL, on fpu_rvalid_i with inflight == 0, set overflow_o, leave inflight at 0, still store the entry if count < DEPTH, drop it otherwise.
REQ-028 SHALL, on fpu_rvalid_i with count == DEPTH and no pop that cycle, set overflow_o and drop the payload (unreachable under correct credit use).
REQ-029 SHALL allow a return into a full buffer when a pop occurs in the same cycle (store succeeds, no overflow).
REQ-030 SHALL hold overflow_o at 1 until reset.
REQ-031 SHALL preserve result order exactly as returned by the FPU; tags are passed through, not interpreted.

Reset
REQ-032 SHALL on rst_n low asynchronously clear inflight, count, pointers, overflow_o; outputs: rvalid_o 0, credits_o DEPTH, overflow_o 0, gnt_o/fpu_req_o follow REQ-019 with DEPTH credits.
REQ-033 SHALL, on reset mid-operation, discard stored and in-flight state; FPU results arriving after reset release count as REQ-027 errors.
REQ-034 SHALL not require payload storage to be reset; rdata_o/rflags_o/rID_o are don't-care while rvalid_o = 0.

Verification
REQ-035 SHALL test single op: DEPTH=4, req/gnt 1 cycle, rvalid_i 3 cycles later with data 0x3F800000, ID 5 -> credits 4->3->3->3, rvalid_o one cycle after return with data 0x3F800000, ID 5; pop -> credits 4.
REQ-036 SHALL test credit exhaustion: req_i held high, fpu_gnt_i 1, rready_i 0, results returned -> exactly 4 grants, then gnt_o=0, fpu_req_o=0, credits_o=0 until one pop, then exactly one more grant.
REQ-037 SHALL test simultaneous issue, return and pop with count=2, inflight=1 -> count stays 2, inflight stays 1, credits_o stays 1.
REQ-038 SHALL test ordering/wrap: 10 back-to-back ops, IDs 0..9, random rready_i -> output IDs 0..9 in order, pointers wrap, no overflow_o.
REQ-039 SHALL test error: fpu_rvalid_i with inflight=0 -> overflow_o=1 next edge, sticky until rst_n asserted; reset asserted with count=3 -> rvalid_o=0, credits_o=4 immediately.
